// File: rtl/ledkey_pkg.sv
// Shared register map, CTRL layout and reset values for the LED/key peripheral.
// LEDKEY_PWM_EN adds the 4-bit BRIGHT field to CTRL.
package ledkey_pkg;

    localparam logic [7:0] COL_BASE      = 8'h00;
    localparam logic [7:0] KEY_STATE_OFS = 8'h40;
    localparam logic [7:0] KEY_PRESS_OFS = 8'h44;
    localparam logic [7:0] CTRL_OFS      = 8'h48;

    localparam int CTRL_SCAN_EN_BIT = 0;
    localparam int CTRL_BRIGHT_LSB  = 8;
    localparam int CTRL_BRIGHT_MSB  = 11;

`ifdef LEDKEY_PWM_EN
    typedef struct packed {
        logic [3:0] bright;
        logic       scan_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{bright: 4'hF, scan_en: 1'b1};

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_SCAN_EN_BIT] = c.scan_en;
        w[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB] = c.bright;
        return w;
    endfunction
`else
    typedef struct packed {
        logic scan_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{scan_en: 1'b1};

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_SCAN_EN_BIT] = c.scan_en;
        return w;
    endfunction
`endif

endpackage

// File: rtl/ledkey_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, debounced state
// and a single-cycle pulse on each accepted press.
module ledkey_debounce #(
    parameter int DEB_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic state_o,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl, differ, hit;

    assign lvl    = ~sync2_q;
    assign differ = lvl ^ state_q;
    assign hit    = differ && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        if (differ) begin
            cnt_d = hit ? '0 : cnt_q + 1'b1;
        end
        if (hit) begin
            state_d = ~state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // synchroniser starts at the released (high) level
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign press_o = hit & lvl;

endmodule

// File: rtl/ledkey_io.sv
// Memory-mapped LED matrix scanner with debounced, sticky key inputs.
// Define LEDKEY_PWM_EN to enable per-slot brightness control via CTRL.BRIGHT.
module ledkey_io
    import ledkey_pkg::*;
#(
    parameter int NCOLS      = 4,
    parameter int NKEYS      = 4,
    parameter int SCAN_DIV   = 3000,
    parameter int DEB_CYCLES = 120000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_select,
    input  logic [7:0]       mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic             mem_wstrobe,
    output logic [31:0]      mem_rdata,
    output logic             mem_done,
    input  logic [NKEYS-1:0] keys_n,
    output logic [7:0]       leds_n,
    output logic [NCOLS-1:0] lcol_n
);

    localparam int SW  = $clog2(SCAN_DIV);
    localparam int CIW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CIW-1:0] COL_LAST  = CIW'(NCOLS - 1);

    logic [7:0]       col_q [NCOLS];
    logic [7:0]       col_d [NCOLS];
    ctrl_t            ctrl_q, ctrl_d;
    logic [NKEYS-1:0] key_state, key_rise;
    logic [NKEYS-1:0] press_q, press_d, w1c;
    logic             done_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [CIW-1:0]   cidx_q, cidx_d;
    logic [7:0]       leds_q, leds_d;
    logic [NCOLS-1:0] lcol_q, lcol_d;
    logic [7:0]       ofs;
    logic             accept, wr, rd;
    logic             scan_en, drive, pwm_ok;
    logic             unused_ok;

    assign ofs    = {mem_addr[7:2], 2'b00};
    assign accept = mem_select & ~done_q;
    assign wr     = accept & mem_wstrobe;
    assign rd     = accept & ~mem_wstrobe;

    assign unused_ok = ^{mem_wdata, mem_addr[1:0]};

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        ledkey_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .key_n_i(keys_n[k]),
            .state_o(key_state[k]),
            .press_o(key_rise[k])
        );
    end

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            for (int c = 0; c < NCOLS; c++) begin
                if (ofs == COL_BASE + 8'(4 * c)) begin
                    rdata_d[7:0] = col_q[c];
                end
            end
            if (ofs == KEY_STATE_OFS) begin
                rdata_d[NKEYS-1:0] = key_state;
            end
            if (ofs == KEY_PRESS_OFS) begin
                rdata_d[NKEYS-1:0] = press_q;
            end
            if (ofs == CTRL_OFS) begin
                rdata_d = ctrl_word(ctrl_q);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCOLS; c++) begin
            col_d[c] = col_q[c];
            if (wr && ofs == COL_BASE + 8'(4 * c)) begin
                col_d[c] = mem_wdata[7:0];
            end
        end
        ctrl_d = ctrl_q;
        if (wr && ofs == CTRL_OFS) begin
            ctrl_d.scan_en = mem_wdata[CTRL_SCAN_EN_BIT];
`ifdef LEDKEY_PWM_EN
            ctrl_d.bright = mem_wdata[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB];
`endif
        end
        w1c = '0;
        if (wr && ofs == KEY_PRESS_OFS) begin
            w1c = mem_wdata[NKEYS-1:0];
        end
        // a new press in the same cycle as its clear must not be lost
        press_d = (press_q & ~w1c) | key_rise;
    end

    // scan follows the enable being written so disable/enable act at once
    assign scan_en = ctrl_d.scan_en;

`ifdef LEDKEY_PWM_EN
    assign pwm_ok = (slot_q[3:0] <= ctrl_q.bright);
`else
    assign pwm_ok = 1'b1;
`endif

    assign drive = scan_en && (slot_q != '0) && pwm_ok;

    always_comb begin
        slot_d = '0;
        cidx_d = '0;
        if (scan_en) begin
            cidx_d = cidx_q;
            if (slot_q == SLOT_LAST) begin
                cidx_d = (cidx_q == COL_LAST) ? '0 : cidx_q + 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
        lcol_d = '1;
        leds_d = '1;
        if (drive) begin
            for (int c = 0; c < NCOLS; c++) begin
                if (cidx_q == CIW'(c)) begin
                    lcol_d[c] = 1'b0;
                    leds_d    = ~col_q[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
            ctrl_q  <= CTRL_RST;
            press_q <= '0;
            slot_q  <= '0;
            cidx_q  <= '0;
            leds_q  <= '1;
            lcol_q  <= '1;
            for (int c = 0; c < NCOLS; c++) begin
                col_q[c] <= '0;
            end
        end else begin
            done_q  <= accept;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            press_q <= press_d;
            slot_q  <= slot_d;
            cidx_q  <= cidx_d;
            leds_q  <= leds_d;
            lcol_q  <= lcol_d;
            for (int c = 0; c < NCOLS; c++) begin
                col_q[c] <= col_d[c];
            end
        end
    end

    assign mem_done  = done_q;
    assign mem_rdata = rdata_q;
    assign leds_n    = leds_q;
    assign lcol_n    = lcol_q;

endmodule

// File: doc/ledkey_io.md
Name: ledkey_io

Overview:
- Memory-mapped LED-matrix and key peripheral on the CPU memory bus; the CPU drives the display and reads the buttons.
- Generalised in column count, key count, scan rate and debounce time.
- Adds sticky key-press flags with write-1-to-clear, and a scan enable.

Parameters:
- NCOLS, 4: LED matrix columns, 1..16; 8 row bits per column.
- NKEYS, 4: push-button inputs, 1..16.
- SCAN_DIV, 3000: clock cycles per column slot; ≥4; multiple of 16 when LEDKEY_PWM_EN is defined.
- DEB_CYCLES, 120000: consecutive stable cycles before a key change is accepted; ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mem_select  in  1  peripheral address decode hit; held until mem_done.
- mem_addr  in  8  byte offset; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrobe  in  1  1 = write, 0 = read.
- mem_rdata  out  32  read data; valid while mem_done = 1.
- mem_done  out  1  one-cycle completion pulse.
- keys_n  in  NKEYS  raw buttons, active-low, asynchronous.
- leds_n  out  8  row drive, active-low.
- lcol_n  out  NCOLS  column drive, one-hot active-low.

Behaviour:
- Reset values:
  - mem_done=0, mem_rdata=0.
  - leds_n all 1, lcol_n all 1.
  - All column registers 0.
  - KEY_STATE=0, KEY_PRESS=0.
  - CTRL = 0x1, scan enabled. With LEDKEY_PWM_EN, brightness resets to 0xF.
  - Scan counters 0. Debouncers hold the released state.
- Register map (byte offsets):
  - 0x00+4c: COL[c], bits [7:0] R/W, c<NCOLS.
  - 0x40: KEY_STATE, bits [NKEYS-1:0] RO; 1 = pressed (debounced).
  - 0x44: KEY_PRESS, sticky; writing 1 clears that bit.
  - 0x48: CTRL; bit0 SCAN_EN, bits [11:8] BRIGHT (PWM build only).
  - Unused bits and unmapped offsets read 0; writes to them are ignored.
- Bus handshake:
  - Transaction accepted in a cycle where mem_select=1 and mem_done=0.
  - Writes take effect at the accept edge.
  - mem_done=1 and mem_rdata valid in the next cycle; latency 1.
  - If select is still held after done, the next transaction is accepted the following cycle (max one transfer per 2 cycles).
  - mem_rdata returns 0 whenever mem_done=0.
- Key path, per key:
  - 2-FF synchroniser, then invert.
  - Counter counts cycles where the synchronised level differs from KEY_STATE; it clears on any agreement.
  - On reaching DEB_CYCLES-1, KEY_STATE toggles and the counter clears.
  - A 0→1 KEY_STATE transition sets KEY_PRESS.
  - A set and a W1C on the same bit in the same cycle: set wins.
- Scan:
  - slot_cnt counts 0..SCAN_DIV-1; col_idx advances 0..NCOLS-1 and wraps at slot end.
  - slot_cnt==0 is a blank cycle: lcol_n all 1.
  - Otherwise lcol_n[col_idx]=0, and leds_n = ~COL[col_idx], registered with 1-cycle output latency.
  - Writing COL during a slot shows up within 2 cycles.
  - SCAN_EN=0: counters held at 0, lcol_n all 1, leds_n all 1. Re-enable restarts at column 0, blank cycle first.
- Reset mid-transaction: mem_done drops to 0 the next cycle and the pending write is discarded.

Optional Feature:
- Macro LEDKEY_PWM_EN.
- Defined:
  - CTRL[11:8] BRIGHT is R/W.
  - Within a non-blank slot cycle, the column is driven only when (slot_cnt mod 16) ≤ BRIGHT.
  - BRIGHT=15 gives full on, apart from the blank cycle.
- Undefined: BRIGHT reads 0, writes to it are ignored, and the display runs at full on.

Decomposition:
- Package ledkey_pkg:
  - Register offset constants: COL_BASE, KEY_STATE_OFS, KEY_PRESS_OFS, CTRL_OFS.
  - CTRL bit positions.
  - Reset value of CTRL.
- Sub-module ledkey_debounce: one key, containing synchroniser, counter, state and press pulse; parameter DEB_CYCLES. Instantiated NKEYS times via generate.

Test Plan:
- Reset (NCOLS=4, SCAN_DIV=16): write COL0=0xA5, COL1=0x3C → slot c0 shows leds_n=0x5A with lcol_n=4'b1110; next slot shows 0xC3 with 4'b1101. Blank cycle at each slot start; wrap from column 3 to 0.
- Bus: read 0x48 after reset → 0x00000001 with done exactly 1 cycle after select. Read 0x4C → 0. Write 0x4C, then read all registers → unchanged.
- Key (DEB_CYCLES=8): press key2 with a 3-cycle bounce, then hold → KEY_STATE=0x4 about 10 cycles after the stable low, KEY_PRESS=0x4. Release → KEY_STATE=0, KEY_PRESS stays 0x4. Write 0x44=0x4 → KEY_PRESS=0.
- W1C collision: write 0x44=0x1 on the same cycle key0 is accepted as pressed → KEY_PRESS bit0 remains 1.
- SCAN_EN: write CTRL=0 mid-slot → lcol_n=all 1 next cycle. Write CTRL=1 → column 0 after one blank cycle.
- PWM build: BRIGHT=3, SCAN_DIV=32 → per slot, lcol active only on the non-blank cycles with slot_cnt mod 16 ≤ 3 (7 cycles). Non-PWM build: CTRL write 0xF01 reads back 0x1.
